swi_debounce: RTL and testbench
===============================

# swi_debounce

Input-side conditioner for the board's slide switches. Synchronises the raw `SWI` bus into the `clk_2` domain, debounces each bit independently, and produces clean levels, one-cycle rise/fall pulses and per-bit toggle state. Every debounced change is also queued as an event on a valid/ready port. Sits between the `SWI` pins and any consumer logic or display driver that needs glitch-free, edge-qualified switch input.

## Interface
- `NBITS`, 8: switch bus width.
- `DB_CYCLES`, 4: consecutive synchronised cycles a new level must hold before acceptance; ≥2. Use 4 in simulation; boards raise it to about 500000.
- `IW`, `$clog2(NBITS)`: event index width (derived).

- `clk_2`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SWI`  in  NBITS  raw, asynchronous switch inputs.
- `swi_clean`  out  NBITS  debounced level.
- `rise`  out  NBITS  one-cycle pulse on each debounced 0→1.
- `fall`  out  NBITS  one-cycle pulse on each debounced 1→0.
- `toggle`  out  NBITS  flips on each `rise` of its bit.
- `ev_valid`  out  1  event slot holds an event.
- `ev_ready`  in  1  consumer accepts the event.
- `ev_bit`  out  IW  index of the changed bit.
- `ev_level`  out  1  new debounced level of `ev_bit`.

## Operation
- **Sync:** two flops per bit, `s1`→`s2`. Both reset to 0.
- **Debounce (per bit):** counter `cnt` of width `$clog2(DB_CYCLES)`.
  - If `s2 == swi_clean`: `cnt`←0.
  - Else if `cnt == DB_CYCLES-1`: `swi_clean`←`s2`, `cnt`←0, and the matching `rise` or `fall` is asserted for that one cycle.
  - Else: `cnt`←`cnt`+1.
  - Any bounce back to the old level before acceptance restarts the count. No saturation or wrap is possible.
- **`toggle[i]`:** registered; inverts in the same edge that asserts `rise[i]`.
- **Pending set:** `pend[NBITS]` and `plev[NBITS]`. A debounced change on bit i sets `pend[i]`←1 and `plev[i]`←new level.
  - A change while `pend[i]` is already set overwrites `plev[i]` (coalesce). No event is lost at bit granularity; the final level is always reported.
- **Event slot:** registered `ev_valid`/`ev_bit`/`ev_level`.
  - **Load:** when the slot is empty, or `ev_valid && ev_ready` (accept), the slot loads the lowest-index set `pend` bit and clears that `pend` bit. If no `pend` bit is set, `ev_valid`←0.
  - **Stability:** while `ev_valid && !ev_ready`, the slot outputs are held stable.
  - **Simultaneous events:** if the bit being loaded also changes on the same edge, the new change wins. `pend[i]` stays 1 with the new level, and the slot takes the pre-edge `plev`.
- **Reset:** all outputs, `s1`, `s2`, `cnt`, `pend`, `plev` and the slot clear to 0 asynchronously, including mid-debounce or mid-handshake. A switch held at 1 through reset debounces normally after release and produces a `rise` plus an event.

## Timing
- Label the first rising edge after `SWI[i]` changes as edge 0.
  - `s2` holds the new value after edge 1.
  - `swi_clean[i]`, `rise`/`fall[i]` and `toggle[i]` update at edge `DB_CYCLES`+1. This is the (`DB_CYCLES`+2)-th edge; edge 5 for the default.
  - `pend[i]` sets at that same edge.
  - With an empty slot, `ev_valid` rises at edge `DB_CYCLES`+2.
- `rise`/`fall` are high for exactly one cycle.
- Event throughput: one per cycle while `ev_ready`=1 and events are pending.
- Minimum accepted pulse width is `DB_CYCLES` cycles at `s2`. Shorter pulses produce no output activity.

## Test plan
- **Reset:** `rst_n`=0 with `SWI`=8'hFF, release → all outputs 0 until edge 5 after release. Then `swi_clean`=8'hFF, `rise`=8'hFF for 1 cycle, and `toggle`=8'hFF.
- **Glitch rejection:** `SWI[3]` 0→1 for 3 cycles, then 0 → `swi_clean`, `rise`, `pend` and `ev_valid` stay 0 throughout.
- **Clean edge with ready high:** `SWI[2]` 0→1 held, `ev_ready`=1 → `swi_clean[2]`=1 and `rise[2]` at edge 5; `ev_valid`=1, `ev_bit`=2, `ev_level`=1 at edge 6; `ev_valid` drops at edge 7.
- **Priority and backpressure:** `SWI[5]` and `SWI[1]` rise on the same cycle, `ev_ready`=0 → slot shows bit 1, level 1, stable for 10 cycles. Pulse `ev_ready` for one cycle → next cycle shows bit 5; second accept → `ev_valid`=0.
- **Coalesce:** with `ev_ready`=0 and slot full (bit 0), toggle `SWI[7]` 0→1→0, each level held 6 cycles → `toggle[7]`=1, one `rise[7]` and one `fall[7]`. After draining: exactly one event, bit 7, `ev_level`=0.
- **Mid-operation reset:** assert `rst_n`=0 at edge 3 of a `SWI[4]` change → all state clears immediately. After release with `SWI[4]` still 1, `swi_clean[4]` rises at edge 5 after release.

Source files
------------

// File: rtl/swi_debounce.sv
// Slide-switch conditioner: two-flop sync, per-bit debounce, edge pulses, toggle state,
// and a coalescing pending set drained lowest-index-first through a valid/ready event slot.
module swi_debounce #(
  parameter int NBITS     = 8,
  parameter int DB_CYCLES = 4,
  parameter int IW        = $clog2(NBITS)
) (
  input  logic             clk_2,
  input  logic             rst_n,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] swi_clean,
  output logic [NBITS-1:0] rise,
  output logic [NBITS-1:0] fall,
  output logic [NBITS-1:0] toggle,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IW-1:0]    ev_bit,
  output logic             ev_level
);

  localparam int            CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [NBITS-1:0] s1;
  logic [NBITS-1:0] s2;
  logic [CW-1:0]    cnt [NBITS];
  logic [NBITS-1:0] differ;
  logic [NBITS-1:0] accept;
  logic [NBITS-1:0] pend;
  logic [NBITS-1:0] plev;
  logic [NBITS-1:0] clear_mask;
  logic [NBITS-1:0] sel_mask;
  logic [IW-1:0]    sel_idx;
  logic             sel_found;
  logic             load;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= SWI;
      s2 <= s1;
    end
  end

  // A bit is accepted once s2 has disagreed with the clean level for DB_CYCLES edges.
  always_comb begin
    differ = '0;
    accept = '0;
    for (int i = 0; i < NBITS; i++) begin
      differ[i] = s2[i] ^ swi_clean[i];
      accept[i] = differ[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBITS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBITS; i++) begin
        if (!differ[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      swi_clean <= '0;
      rise      <= '0;
      fall      <= '0;
      toggle    <= '0;
    end else begin
      swi_clean <= swi_clean ^ accept;
      rise      <= accept & s2;
      fall      <= accept & ~s2;
      toggle    <= toggle ^ (accept & s2);
    end
  end

  // Lowest-index pending bit wins the slot.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_mask  = '0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
    if (sel_found) begin
      sel_mask[sel_idx] = 1'b1;
    end
  end

  assign load       = !ev_valid || ev_ready;
  assign clear_mask = load ? sel_mask : '0;

  // A fresh change on the bit being loaded re-arms pend, so the newer level is never lost.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      plev <= '0;
    end else begin
      pend <= (pend & ~clear_mask) | accept;
      plev <= (plev & ~accept) | (s2 & accept);
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_bit   <= '0;
      ev_level <= 1'b0;
    end else if (load) begin
      ev_valid <= sel_found;
      if (sel_found) begin
        ev_bit   <= sel_idx;
        ev_level <= plev[sel_idx];
      end
    end
  end

  a_rise_fall_exclusive : assert property (
    @(posedge clk_2) disable iff (!rst_n) ((rise & fall) == '0));

  a_slot_stable : assert property (
    @(posedge clk_2) disable iff (!rst_n)
    (ev_valid && !ev_ready) |=> (ev_valid && $stable(ev_bit) && $stable(ev_level)));

endmodule

// File: tb/tb_swi_debounce.sv
// Bench for swi_debounce: directed scenarios plus random switch bouncing, checked
// against a sliding-window reference model and an event scoreboard.
module tb_swi_debounce;

  localparam int NB = 8;
  localparam int DB = 4;
  localparam int IW = 3;

  logic          clk_2 = 1'b0;
  logic          rst_n;
  logic [NB-1:0] SWI;
  logic [NB-1:0] swi_clean;
  logic [NB-1:0] rise;
  logic [NB-1:0] fall;
  logic [NB-1:0] toggle;
  logic          ev_valid;
  logic          ev_ready;
  logic [IW-1:0] ev_bit;
  logic          ev_level;

  int n_checks = 0;
  int n_errors = 0;

  swi_debounce #(.NBITS(NB), .DB_CYCLES(DB), .IW(IW)) dut (
    .clk_2    (clk_2),
    .rst_n    (rst_n),
    .SWI      (SWI),
    .swi_clean(swi_clean),
    .rise     (rise),
    .fall     (fall),
    .toggle   (toggle),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_bit   (ev_bit),
    .ev_level (ev_level)
  );

  always #5 clk_2 = ~clk_2;

  // Reference model: a level is accepted when the last DB synchronised samples all
  // disagree with the current clean level.
  logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_rise = '0, m_fall = '0;
  logic [NB-1:0] m_toggle = '0, m_pend = '0, m_plev = '0, m_acc = '0;
  logic          m_valid = 1'b0;
  logic          m_ok;
  logic [NB-1:0] m_seen[$];
  logic [IW:0]   exp_q[$];

  always @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
      m_toggle = '0; m_pend = '0; m_plev = '0; m_valid = 1'b0;
      m_seen.delete();
      exp_q.delete();
    end else begin
      m_seen.push_back(m_s2);
      if (m_seen.size() > DB) void'(m_seen.pop_front());
      m_acc = '0;
      if (m_seen.size() == DB) begin
        for (int i = 0; i < NB; i++) begin
          m_ok = 1'b1;
          foreach (m_seen[j]) if (m_seen[j][i] == m_clean[i]) m_ok = 1'b0;
          m_acc[i] = m_ok;
        end
      end
      m_rise   = m_acc & ~m_clean;
      m_fall   = m_acc & m_clean;
      m_clean  = m_clean ^ m_acc;
      m_toggle = m_toggle ^ m_rise;
      if (!m_valid || ev_ready) begin
        m_valid = 1'b0;
        for (int i = 0; i < NB && !m_valid; i++) begin
          if (m_pend[i]) begin
            m_valid = 1'b1;
            exp_q.push_back({IW'(i), m_plev[i]});
            m_pend[i] = 1'b0;
          end
        end
      end
      m_pend = m_pend | m_acc;
      m_plev = (m_plev & ~m_acc) | (m_clean & m_acc);
      m_s2 = m_s1;
      m_s1 = SWI;
    end
  end

  always @(negedge clk_2) begin
    n_checks++;
    if ({swi_clean, rise, fall, toggle} !== {m_clean, m_rise, m_fall, m_toggle}) begin
      n_errors++;
      $display("[TB] FAIL levels: got clean=%h rise=%h fall=%h toggle=%h expected clean=%h rise=%h fall=%h toggle=%h",
               swi_clean, rise, fall, toggle, m_clean, m_rise, m_fall, m_toggle);
    end
    n_checks++;
    if (ev_valid !== m_valid) begin
      n_errors++;
      $display("[TB] FAIL ev_valid: got %b expected %b", ev_valid, m_valid);
    end
    if (m_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("[TB] FAIL sb_underflow: got slot with no expected event, expected queue entry");
      end else begin
        if ({ev_bit, ev_level} !== exp_q[0]) begin
          n_errors++;
          $display("[TB] FAIL event: got bit=%0d level=%b expected bit=%0d level=%b",
                   ev_bit, ev_level, exp_q[0][IW:1], exp_q[0][0]);
        end
        if (ev_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic apply_stimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      step();
      #1;
      for (int i = 0; i < NB; i++) if ($urandom_range(4) == 0) SWI[i] = ~SWI[i];
      ev_ready = ($urandom_range(2) != 0);
      if (c == cycles / 2) rst_n = 1'b0;
      if (c == cycles / 2 + 2) rst_n = 1'b1;
    end
  endtask

  int n7;
  int n_r;
  int n_f;
  logic lev7;

  initial begin
    SWI = 8'hFF; ev_ready = 1'b0; rst_n = 1'b0;
    repeat (3) step();
    #1 rst_n = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      if (k < 5) check_output("rst_quiet", {swi_clean, rise, toggle, ev_valid}, 0);
      if (k == 5) begin
        check_output("rst_clean", swi_clean, 8'hFF);
        check_output("rst_rise", rise, 8'hFF);
        check_output("rst_toggle", toggle, 8'hFF);
      end
      if (k == 6) begin
        check_output("rst_rise_pulse", rise, 0);
        check_output("rst_first_ev", {ev_valid, ev_bit, ev_level}, {1'b1, 3'd0, 1'b1});
      end
    end
    #1 ev_ready = 1'b1;
    repeat (12) step();
    check_output("rst_drained", ev_valid, 0);

    #1 SWI = '0; rst_n = 1'b0;
    step();
    #1 rst_n = 1'b1;
    repeat (3) step();
    check_output("zero_reset", {swi_clean, toggle, ev_valid}, 0);

    #1 SWI[3] = 1'b1;
    repeat (3) step();
    #1 SWI[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_output("glitch", {swi_clean, rise, ev_valid}, 0);
    end

    #1 SWI[2] = 1'b1; ev_ready = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      if (k == 4) check_output("edge_early", swi_clean, 0);
      if (k == 5) begin
        check_output("edge_clean", swi_clean, 8'h04);
        check_output("edge_rise", rise, 8'h04);
      end
      if (k == 6) check_output("edge_ev", {ev_valid, ev_bit, ev_level}, {1'b1, 3'd2, 1'b1});
      if (k == 7) check_output("edge_ev_drop", ev_valid, 0);
    end

    #1 ev_ready = 1'b0; SWI[5] = 1'b1; SWI[1] = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      step();
      if (k >= 6) check_output("prio_hold", {ev_valid, ev_bit, ev_level}, {1'b1, 3'd1, 1'b1});
    end
    #1 ev_ready = 1'b1;
    step();
    check_output("prio_next", {ev_valid, ev_bit, ev_level}, {1'b1, 3'd5, 1'b1});
    step();
    check_output("prio_empty", ev_valid, 0);

    #1 ev_ready = 1'b0; SWI[0] = 1'b1;
    repeat (7) step();
    check_output("coal_slot", {ev_valid, ev_bit, ev_level}, {1'b1, 3'd0, 1'b1});
    n_r = 0; n_f = 0;
    #1 SWI[7] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_r += int'(rise[7]); n_f += int'(fall[7]);
    end
    #1 SWI[7] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      n_r += int'(rise[7]); n_f += int'(fall[7]);
    end
    check_output("coal_toggle", toggle[7], 1);
    check_output("coal_rises", n_r, 1);
    check_output("coal_falls", n_f, 1);
    check_output("coal_slot_held", {ev_valid, ev_bit, ev_level}, {1'b1, 3'd0, 1'b1});
    n7 = 0; lev7 = 1'b1;
    #1 ev_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ev_valid && ev_bit == 3'd7) begin
        n7++;
        lev7 = ev_level;
      end
    end
    check_output("coal_count", n7, 1);
    check_output("coal_level", lev7, 0);
    check_output("coal_empty", ev_valid, 0);

    #1 ev_ready = 1'b0; SWI[4] = 1'b1;
    repeat (4) step();
    #1 rst_n = 1'b0;
    #1 check_output("mreset_clear", {swi_clean, rise, fall, toggle, ev_valid, ev_bit, ev_level}, 0);
    step();
    #1 rst_n = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k < 5) check_output("mreset_hold", swi_clean[4], 0);
      if (k == 5) check_output("mreset_clean", swi_clean, 8'h37);
    end

    apply_stimulus(600);
    #1 ev_ready = 1'b1;
    repeat (30) step();
    check_output("final_clean", swi_clean, SWI);
    check_output("final_empty", ev_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
